// File: rtl/vend_pkg.sv
// Shared types and constants for the drink vending transaction controller.
package vend_pkg;

   typedef enum logic [1:0] {IDLE, VEND, CHANGE} vend_state_t;

   localparam logic [2:0] DRINK_NONE   = 3'b000;
   localparam logic [2:0] DRINK_TEA    = 3'b001;
   localparam logic [2:0] DRINK_COKE   = 3'b010;
   localparam logic [2:0] DRINK_COFFEE = 3'b011;
   localparam logic [2:0] DRINK_MILK   = 3'b100;

   localparam logic [6:0] COIN_1  = 7'd1;
   localparam logic [6:0] COIN_5  = 7'd5;
   localparam logic [6:0] COIN_10 = 7'd10;
   localparam logic [6:0] COIN_50 = 7'd50;

   localparam logic [6:0] CHG_10 = 7'd10;
   localparam logic [6:0] CHG_5  = 7'd5;
   localparam logic [6:0] CHG_1  = 7'd1;

   function automatic logic coin_denom_ok(input logic [6:0] c);
      return (c == COIN_1) || (c == COIN_5) || (c == COIN_10) || (c == COIN_50);
   endfunction

endpackage

// File: rtl/vend_change_pick.sv
// Greedy change selector: largest of 10/5/1 not exceeding the remainder (0 when nothing is owed).
module vend_change_pick
   import vend_pkg::*;
(
   input  logic [6:0] remainder,
   output logic [6:0] coin_val
);

   always_comb begin
      coin_val = 7'd0;
      if (remainder >= CHG_10)
         coin_val = CHG_10;
      else if (remainder >= CHG_5)
         coin_val = CHG_5;
      else if (remainder >= CHG_1)
         coin_val = CHG_1;
   end

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: credit accumulation, drink release handshake and change payout.
// Optional VEND_TIMEOUT_EN: abort a dispense after DISP_TIMEOUT cycles without drink_ack.
module vend_sequencer
   import vend_pkg::*;
#(
   parameter int PRICE_TEA    = 10,
   parameter int PRICE_COKE   = 15,
   parameter int PRICE_COFFEE = 20,
   parameter int PRICE_MILK   = 25,
   parameter int CREDIT_MAX   = 99,
   parameter int DISP_TIMEOUT = 255
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] coin,
   input  logic       coin_valid,
   input  logic [2:0] drink_choose,
   input  logic       cancel,
   output logic       drink_req,
   output logic [2:0] drink_id,
   input  logic       drink_ack,
   output logic       coin_out_valid,
   output logic [6:0] coin_out_val,
   input  logic       coin_out_ready,
   output logic [6:0] total_coin,
   output logic [6:0] refund,
   output logic       coin_reject,
   output logic       busy,
   output logic       timeout_fault
);

   vend_state_t state_reg, state_next;
   logic [6:0]  credit_reg, credit_next;
   logic [6:0]  refund_reg, refund_next;
   logic [2:0]  drink_id_reg, drink_id_next;
   logic        reject_reg, reject_next;
   logic [7:0]  coin_sum;
   logic [6:0]  vend_remain;
   logic [6:0]  chg_val;

   function automatic logic [6:0] price_of(input logic [2:0] d);
      case (d)
         DRINK_TEA:    return 7'(PRICE_TEA);
         DRINK_COKE:   return 7'(PRICE_COKE);
         DRINK_COFFEE: return 7'(PRICE_COFFEE);
         DRINK_MILK:   return 7'(PRICE_MILK);
         default:      return 7'd0;
      endcase
   endfunction

   vend_change_pick u_change_pick (
      .remainder (credit_reg),
      .coin_val  (chg_val)
   );

   // Widened so a large coin on a nearly full credit cannot wrap past the limit check.
   assign coin_sum    = {1'b0, credit_reg} + {1'b0, coin};
   assign vend_remain = credit_reg - price_of(drink_id_reg);

`ifdef VEND_TIMEOUT_EN
   localparam int TO_W = $clog2(DISP_TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
   logic            fault_reg, fault_next;
`endif

   always_comb begin
      state_next    = state_reg;
      credit_next   = credit_reg;
      refund_next   = refund_reg;
      drink_id_next = drink_id_reg;
      reject_next   = 1'b0;
`ifdef VEND_TIMEOUT_EN
      to_cnt_next   = to_cnt_reg;
      fault_next    = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (coin_valid) begin
               if (coin_denom_ok(coin) && (coin_sum <= 8'(CREDIT_MAX)))
                  credit_next = coin_sum[6:0];
               else
                  reject_next = 1'b1;
            end else if ((drink_choose != DRINK_NONE) && (drink_choose <= DRINK_MILK) &&
                         (credit_reg >= price_of(drink_choose))) begin
               drink_id_next = drink_choose;
               state_next    = VEND;
`ifdef VEND_TIMEOUT_EN
               to_cnt_next   = '0;
`endif
            end else if (cancel && (credit_reg != 7'd0)) begin
               refund_next = credit_reg;
               state_next  = CHANGE;
            end
         end
         VEND: begin
            reject_next = coin_valid;
            if (drink_ack) begin
               credit_next = vend_remain;
               refund_next = vend_remain;
               state_next  = (vend_remain != 7'd0) ? CHANGE : IDLE;
            end
`ifdef VEND_TIMEOUT_EN
            else if (to_cnt_reg == TO_W'(DISP_TIMEOUT - 1)) begin
               fault_next  = 1'b1;
               refund_next = credit_reg;
               state_next  = CHANGE;
            end else begin
               to_cnt_next = to_cnt_reg + 1'b1;
            end
`endif
         end
         CHANGE: begin
            reject_next = coin_valid;
            if (coin_out_ready) begin
               credit_next = credit_reg - chg_val;
               if (credit_reg == chg_val)
                  state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         credit_reg   <= '0;
         refund_reg   <= '0;
         drink_id_reg <= DRINK_NONE;
         reject_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         credit_reg   <= credit_next;
         refund_reg   <= refund_next;
         drink_id_reg <= drink_id_next;
         reject_reg   <= reject_next;
      end
   end

`ifdef VEND_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt_reg <= '0;
         fault_reg  <= 1'b0;
      end else begin
         to_cnt_reg <= to_cnt_next;
         fault_reg  <= fault_next;
      end
   end
   assign timeout_fault = fault_reg;
`else
   assign timeout_fault = 1'b0;
`endif

   // Handshake outputs decode from the state register so an asynchronous reset drops them at once.
   assign drink_req      = (state_reg == VEND);
   assign coin_out_valid = (state_reg == CHANGE);
   assign coin_out_val   = (state_reg == CHANGE) ? chg_val : 7'd0;
   assign drink_id       = drink_id_reg;
   assign total_coin     = credit_reg;
   assign refund         = refund_reg;
   assign coin_reject    = reject_reg;
   assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer; exercises the timeout path when VEND_TIMEOUT_EN is defined.
module tb_vend_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] coin = '0;
   logic       coin_valid = 1'b0;
   logic [2:0] drink_choose = '0;
   logic       cancel = 1'b0;
   logic       drink_req;
   logic [2:0] drink_id;
   logic       drink_ack = 1'b0;
   logic       coin_out_valid;
   logic [6:0] coin_out_val;
   logic       coin_out_ready = 1'b0;
   logic [6:0] total_coin;
   logic [6:0] refund;
   logic       coin_reject;
   logic       busy;
   logic       timeout_fault;

   int checks = 0;
   int failures = 0;
   int got_vals[8];
   int got_n;

   always #5 clk = ~clk;

   vend_sequencer #(.DISP_TIMEOUT(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .coin           (coin),
      .coin_valid     (coin_valid),
      .drink_choose   (drink_choose),
      .cancel         (cancel),
      .drink_req      (drink_req),
      .drink_id       (drink_id),
      .drink_ack      (drink_ack),
      .coin_out_valid (coin_out_valid),
      .coin_out_val   (coin_out_val),
      .coin_out_ready (coin_out_ready),
      .total_coin     (total_coin),
      .refund         (refund),
      .coin_reject    (coin_reject),
      .busy           (busy),
      .timeout_fault  (timeout_fault)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic insert(input int val);
      coin = 7'(val);
      coin_valid = 1'b1;
      step();
      coin_valid = 1'b0;
      coin = '0;
   endtask

   task automatic pulse_select(input logic [2:0] code);
      drink_choose = code;
      step();
      drink_choose = '0;
   endtask

   task automatic pulse_ack();
      drink_ack = 1'b1;
      step();
      drink_ack = 1'b0;
   endtask

   // Drains the payout; optionally stalls the hopper before accepting coin number stall_at.
   task automatic payout(input int stall_at, input int stall_len);
      int guard;
      int held;
      guard = 0;
      got_n = 0;
      while (coin_out_valid && guard < 40) begin
         if (got_n == stall_at) begin
            coin_out_ready = 1'b0;
            held = int'(coin_out_val);
            for (int s = 0; s < stall_len; s++) begin
               step();
               check_eq("stall_valid", int'(coin_out_valid), 1);
               check_eq("stall_val", int'(coin_out_val), held);
            end
         end
         coin_out_ready = 1'b1;
         if (got_n < 8) got_vals[got_n] = int'(coin_out_val);
         got_n++;
         step();
         coin_out_ready = 1'b0;
         guard++;
      end
      check_eq("payout_idle", int'(busy), 0);
   endtask

   initial begin
      step();
      check_eq("rst_total", int'(total_coin), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_req", int'(drink_req), 0);
      check_eq("rst_outv", int'(coin_out_valid), 0);
      reset = 1'b0;
      step();

      // 10+5+5 then coke: 5 change as one coin
      insert(10); insert(5); insert(5);
      check_eq("t1_total", int'(total_coin), 20);
      pulse_select(3'b010);
      check_eq("t1_req", int'(drink_req), 1);
      check_eq("t1_id", int'(drink_id), 2);
      repeat (10) step();
      check_eq("t1_req_held", int'(drink_req), 1);
      check_eq("t1_nofault", int'(timeout_fault), 0);
      pulse_ack();
      check_eq("t1_refund", int'(refund), 5);
      check_eq("t1_outv", int'(coin_out_valid), 1);
      payout(-1, 0);
      check_eq("t1_ncoins", got_n, 1);
      check_eq("t1_coin0", got_vals[0], 5);
      check_eq("t1_total0", int'(total_coin), 0);

      // 50 then milk: 25 change as 10,10,5 with a stall
      insert(50);
      pulse_select(3'b100);
      check_eq("t2_id", int'(drink_id), 4);
      pulse_ack();
      check_eq("t2_refund", int'(refund), 25);
      check_eq("t2_total", int'(total_coin), 25);
      payout(1, 3);
      check_eq("t2_ncoins", got_n, 3);
      check_eq("t2_coin0", got_vals[0], 10);
      check_eq("t2_coin1", got_vals[1], 10);
      check_eq("t2_coin2", got_vals[2], 5);

      // credit limit and bad denomination
      insert(50);
      check_eq("t3_rej0", int'(coin_reject), 0);
      insert(50);
      check_eq("t3_rej_over", int'(coin_reject), 1);
      check_eq("t3_total", int'(total_coin), 50);
      step();
      check_eq("t3_rej_pulse", int'(coin_reject), 0);
      insert(3);
      check_eq("t3_rej_bad", int'(coin_reject), 1);
      check_eq("t3_total2", int'(total_coin), 50);
      cancel = 1'b1; step(); cancel = 1'b0;
      check_eq("t3_refund", int'(refund), 50);
      payout(-1, 0);
      check_eq("t3_ncoins", got_n, 5);

      // insufficient credit and invalid code, then cancel
      insert(10);
      pulse_select(3'b100);
      check_eq("t4_noreq", int'(drink_req), 0);
      pulse_select(3'b101);
      check_eq("t4_badcode", int'(busy), 0);
      check_eq("t4_total", int'(total_coin), 10);
      cancel = 1'b1; step(); cancel = 1'b0;
      check_eq("t4_val", int'(coin_out_val), 10);
      payout(-1, 0);
      check_eq("t4_ncoins", got_n, 1);
      check_eq("t4_coin0", got_vals[0], 10);
      check_eq("t4_total0", int'(total_coin), 0);

      // coin and selection together: coin wins, vend one cycle later
      pulse_ack();
      check_eq("t5_ack_idle", int'(busy), 0);
      drink_choose = 3'b001; coin = 7'd10; coin_valid = 1'b1;
      step();
      coin_valid = 1'b0; coin = '0;
      check_eq("t5_total", int'(total_coin), 10);
      check_eq("t5_noreq", int'(drink_req), 0);
      step();
      drink_choose = '0;
      check_eq("t5_req", int'(drink_req), 1);
      insert(5);
      check_eq("t5_busy_rej", int'(coin_reject), 1);
      check_eq("t5_busy_total", int'(total_coin), 10);
      pulse_ack();
      check_eq("t5_exact_idle", int'(busy), 0);
      check_eq("t5_exact_outv", int'(coin_out_valid), 0);

      // asynchronous reset during CHANGE
      insert(10); insert(5);
      pulse_select(3'b001);
      pulse_ack();
      check_eq("t6_outv", int'(coin_out_valid), 1);
      #2 reset = 1'b1;
      #1;
      check_eq("t6_rst_outv", int'(coin_out_valid), 0);
      check_eq("t6_rst_val", int'(coin_out_val), 0);
      check_eq("t6_rst_total", int'(total_coin), 0);
      check_eq("t6_rst_refund", int'(refund), 0);
      check_eq("t6_rst_busy", int'(busy), 0);
      step();
      reset = 1'b0;
      step();

`ifdef VEND_TIMEOUT_EN
      begin
         int n;
         insert(10); insert(10);
         pulse_select(3'b001);
         n = 0;
         while (!timeout_fault && n < 20) begin
            step();
            n++;
         end
         check_eq("t7_to_cycles", n, 8);
         check_eq("t7_refund", int'(refund), 20);
         step();
         check_eq("t7_pulse", int'(timeout_fault), 0);
         payout(-1, 0);
         check_eq("t7_ncoins", got_n, 2);
         check_eq("t7_coin0", got_vals[0], 10);
         check_eq("t7_coin1", got_vals[1], 10);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Transaction controller for the drink vending datapath. Accumulates inserted coins into a credit register and validates drink selections against the price list. Sequences the drink-release mechanism through a req/ack handshake, then pays out change one coin at a time through a valid/ready handshake to the coin hopper. Sits between the front-panel inputs (coin slot, selector buttons, cancel) and the physical dispense and hopper actuators.

## Interface
Parameters:
- PRICE_TEA, 10, price of tea (drink code 3'b001)
- PRICE_COKE, 15, price of coke (3'b010)
- PRICE_COFFEE, 20, price of coffee (3'b011)
- PRICE_MILK, 25, price of milk (3'b100)
- CREDIT_MAX, 99, maximum credit held; must be ≤ 127
- DISP_TIMEOUT, 255, cycles to wait for drink_ack (used only with VEND_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- coin  in  7  value of the inserted coin
- coin_valid  in  1  coin presents a value this cycle
- drink_choose  in  3  selection code; 3'b000 means no selection
- cancel  in  1  request refund of all credit
- drink_req  out  1  release request to the dispense mechanism
- drink_id  out  3  code of the drink being released
- drink_ack  in  1  dispense mechanism done
- coin_out_valid  out  1  change coin presented to the hopper
- coin_out_val  out  7  change coin denomination (10, 5 or 1)
- coin_out_ready  in  1  hopper accepted the coin
- total_coin  out  7  current credit
- refund  out  7  change amount latched at start of payout
- coin_reject  out  1  one-cycle pulse: coin not accepted
- busy  out  1  high in any state other than IDLE
- timeout_fault  out  1  one-cycle pulse on dispense timeout

## Operation
- States: IDLE, VEND, CHANGE.
- **IDLE**
  - A coin with coin_valid is accepted if its value is 1, 5, 10 or 50 and total_coin + coin ≤ CREDIT_MAX. Otherwise coin_reject pulses and credit is unchanged.
  - Otherwise, if drink_choose is 001–100 and total_coin ≥ its price: latch drink_id and go to VEND.
  - Codes 101–111, or insufficient credit: the selection is ignored and credit is retained.
  - Otherwise, if cancel is high and total_coin > 0: refund <= total_coin, go to CHANGE.
  - Priority: coin > selection > cancel. A selection or cancel in the same cycle as coin_valid is ignored and must be held to the next cycle.
- **VEND**
  - drink_req is high and drink_id is stable.
  - On drink_ack: total_coin <= total_coin − price and refund <= total_coin − price. Go to CHANGE if the remainder is > 0, else to IDLE.
- **CHANGE**
  - coin_out_val is the largest of {10, 5, 1} that is ≤ total_coin; coin_out_valid is high.
  - On coin_out_ready: total_coin <= total_coin − coin_out_val.
  - Return to IDLE when total_coin reaches 0.
- Inputs coin_valid, drink_choose and cancel are ignored while busy. Coins presented while busy are rejected (coin_reject pulses).
- All arithmetic is 7-bit unsigned. Subtraction cannot underflow because of the guards above.

## Timing
- Reset values: all outputs 0, state IDLE.
- Reset mid-transaction: state returns to IDLE, credit is discarded, drink_req and coin_out_valid drop immediately (asynchronous).
- A coin is registered at the clock edge where coin_valid is sampled. total_coin reflects it on the following cycle.
- Selection to drink_req: 1 cycle.
- drink_ack to the first coin_out_valid: 1 cycle.
- Each accepted change coin updates coin_out_val on the next cycle. A payout of N coins takes at least N cycles.
- drink_req is held until drink_ack; drink_ack while not in VEND is ignored.
- coin_out_valid and coin_out_val are held stable until coin_out_ready.

## Configuration
- VEND_TIMEOUT_EN
  - Defined: a counter runs in VEND. If DISP_TIMEOUT cycles pass without drink_ack, timeout_fault pulses, no price is deducted, refund <= total_coin, and the block goes to CHANGE, refunding the full credit. The counter clears on entering VEND.
  - Undefined: VEND waits indefinitely, and timeout_fault is tied to 0.

## Structure
- Package vend_pkg holds:
  - state enum (IDLE, VEND, CHANGE)
  - drink code constants (DRINK_NONE, DRINK_TEA, DRINK_COKE, DRINK_COFFEE, DRINK_MILK)
  - accepted coin denomination constants
  - change denominations 10, 5, 1
- Sub-module vend_change_pick: purely combinational greedy denomination selector from a 7-bit remainder.

## Test plan
- Insert 10, 5, 5, then select coke (010): drink_req, then ack → refund = 5, exactly one coin_out of 5, total_coin = 0, back to IDLE.
- Insert 50, then select milk (100) and ack: refund = 25, with coins output in order 10, 10, 5. Hold coin_out_ready low for 3 cycles mid-payout and check valid and value stay stable.
- Insert 50, 50: the second coin is rejected (credit 100 > 99) with a coin_reject pulse and total_coin stays 50. A coin of value 3 also pulses coin_reject.
- Insert 10, select milk: no drink_req. Then cancel: one coin_out of 10, total_coin = 0.
- coin_valid and drink_choose in the same cycle: the coin is credited and the vend starts one cycle later. Assert reset during CHANGE: all outputs go to 0 immediately.
- With VEND_TIMEOUT_EN and DISP_TIMEOUT = 8: insert 20, select tea, never ack. timeout_fault pulses after 8 cycles, and 10 + 10 are refunded.
